// File: rtl/ad1939_tdm_serdes.sv
// AD1939 TDM serializer/deserializer: recovers frame timing from the
// asynchronous ADC clocks and drives the DAC side from a shadowed tx buffer.
module ad1939_tdm_serdes #(
  parameter int N_CH = 2,
  parameter int W_DATA = 24,
  parameter int W_SLOT = 32,
  parameter int DELAY = 1,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int FRAME = N_CH * W_SLOT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              abclk,
  input  logic              alrclk,
  input  logic              asdata,
  output logic              dsdata,
  output logic              dbclk,
  output logic              dlrclk,
  output logic [W_DATA-1:0] rx_data,
  output logic [CW-1:0]     rx_channel,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [W_DATA-1:0] tx_data,
  input  logic [CW-1:0]     tx_channel,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              clear_status,
  output logic              locked,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_err
);

  localparam int BCW = $clog2(FRAME);
  localparam int KW = BCW + 1;
  typedef logic [KW-1:0] k_t;
  localparam k_t K_DEL = k_t'(DELAY);
  localparam k_t K_WS = k_t'(W_SLOT);
  localparam k_t K_WD = k_t'(W_DATA);
  localparam k_t K_WDM1 = k_t'(W_DATA - 1);
  localparam k_t K_NCH = k_t'(N_CH);
  localparam logic [BCW-1:0] BC_MAX = BCW'(FRAME - 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;
  state_t state_q, state_d;

  logic [2:0]        ab_q, lr_q, ad_q;
  logic              rise_q, fall_q, lrp_q;
  logic [BCW-1:0]    bc_q, bc_d;
  logic [W_DATA-2:0] sh_q;
  logic [W_DATA-1:0] sh_nx, rx_data_q;
  logic [CW-1:0]     rx_ch_q;
  logic              rx_valid_q, ds_q, tx_ready_q;
  logic              ovr_q, und_q, ferr_q;
  logic [W_DATA-1:0] buf_q [N_CH];
  logic [W_DATA-1:0] shd_q [N_CH];
  logic [N_CH-1:0]   fresh_q;

  logic fs, at_max, ferr_ev, rx_on, rx_done;
  logic tx_wr, tx_bit, ovr_ev, und_ev;
  k_t   kr, pr, kt, pt, st;

  always_comb begin
    fs = rise_q & ~lr_q[2] & lrp_q;
    at_max = (bc_q == BC_MAX);
    bc_d = bc_q;
    if (rise_q) begin
      if (fs) bc_d = '0;
      else if (!at_max) bc_d = bc_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ferr_ev = 1'b0;
    unique case (state_q)
      UNLOCKED: if (fs) state_d = LOCKED;
      LOCKED: begin
        if (rise_q && !fs && at_max) begin
          state_d = UNLOCKED;
          ferr_ev = 1'b1;
        end else if (fs && !at_max) begin
          ferr_ev = 1'b1;
        end
      end
    endcase
  end

  // rx samples at the post-rise count; tx looks one bit ahead
  always_comb begin
    kr = {1'b0, bc_d} - K_DEL;
    pr = kr % K_WS;
    rx_on = rise_q && (state_d == LOCKED)
         && ({1'b0, bc_d} >= K_DEL) && (pr < K_WD);
    rx_done = rx_on && (pr == K_WDM1);
    sh_nx = {sh_q, ad_q[2]};
    kt = {1'b0, bc_q} + 1'b1 - K_DEL;
    pt = kt % K_WS;
    st = kt / K_WS;
    tx_bit = (state_q == LOCKED) && (st < K_NCH) && (pt < K_WD)
          && |(shd_q[CW'(st)] & (W_DATA'(1) << (K_WDM1 - pt)));
    tx_wr = tx_valid && (32'(tx_channel) < N_CH);
    ovr_ev = rx_done && rx_valid_q && !rx_ready;
    und_ev = fs && !(&fresh_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ab_q <= '0;
      lr_q <= '0;
      ad_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      lrp_q <= 1'b0;
      bc_q <= '0;
      state_q <= UNLOCKED;
      sh_q <= '0;
      rx_data_q <= '0;
      rx_ch_q <= '0;
      rx_valid_q <= 1'b0;
      ds_q <= 1'b0;
      tx_ready_q <= 1'b0;
      ovr_q <= 1'b0;
      und_q <= 1'b0;
      ferr_q <= 1'b0;
      fresh_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        buf_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      ab_q <= {ab_q[1:0], abclk};
      lr_q <= {lr_q[1:0], alrclk};
      ad_q <= {ad_q[1:0], asdata};
      rise_q <= ab_q[1] & ~ab_q[2];
      fall_q <= ~ab_q[1] & ab_q[2];
      if (rise_q) lrp_q <= lr_q[2];
      bc_q <= bc_d;
      state_q <= state_d;
      tx_ready_q <= 1'b1;
      if (rx_on) sh_q <= sh_nx[W_DATA-2:0];
      if (rx_done) begin
        rx_data_q <= sh_nx;
        rx_ch_q <= CW'(kr / K_WS);
        rx_valid_q <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (state_d == UNLOCKED) ds_q <= 1'b0;
      else if (fall_q) ds_q <= tx_bit;
      // a write landing on the frame-start cycle belongs to the next frame
      if (fs) begin
        for (int i = 0; i < N_CH; i++) shd_q[i] <= buf_q[i];
        fresh_q <= '0;
      end
      if (tx_wr) begin
        buf_q[tx_channel] <= tx_data;
        fresh_q[tx_channel] <= 1'b1;
      end
      ovr_q <= (ovr_q & ~clear_status) | ovr_ev;
      und_q <= (und_q & ~clear_status) | und_ev;
      ferr_q <= (ferr_q & ~clear_status) | ferr_ev;
    end
  end

  assign dsdata = ds_q;
  assign dbclk = ab_q[2];
  assign dlrclk = lr_q[2];
  assign rx_data = rx_data_q;
  assign rx_channel = rx_ch_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign locked = (state_q == LOCKED);
  assign rx_overrun = ovr_q;
  assign tx_underrun = und_q;
  assign frame_err = ferr_q;

endmodule
